// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: grants one initiator at a time, watches FRAME/IRDY
// for bus idle, revokes unused grants after GNT_TIMEOUT and bounds contended tenures.
module pci_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int MAX_PHASES  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic             FRAME,
  input  logic             IRDY,
  input  logic             TRDY,
  output logic [N_REQ-1:0] GNT,
  output logic [2:0]       OWNER,
  output logic             OWNER_VALID,
  output logic             BUS_IDLE,
  output logic             TIMEOUT_EV
);

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_BUSY, S_TURN} state_t;

  state_t           state_q, state_nxt;
  logic [2:0]       ptr_q, ptr_nxt;
  logic [2:0]       owner_q, owner_nxt;
  logic             owner_vld_q, owner_vld_nxt;
  logic [N_REQ-1:0] gnt_q, gnt_nxt;
  logic [7:0]       tcnt_q, tcnt_nxt;
  logic [7:0]       pcnt_q, pcnt_nxt;
  logic             tmo_q, tmo_nxt;
  logic             bus_idle_q;

  logic             bus_idle_now;
  logic             data_phase;
  logic [7:0]       pcnt_upd;
  logic             owner_req;
  logic             others_req;
  logic             tmo_hit;
  logic             budget_hit;
  logic             win_vld;
  logic [2:0]       win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [3:0]       cand;

  assign bus_idle_now = FRAME & IRDY;
  assign data_phase   = ~IRDY & ~TRDY;
  assign pcnt_upd     = (data_phase && pcnt_q != 8'hFF) ? pcnt_q + 8'd1 : pcnt_q;
  assign tmo_hit      = bus_idle_now && (tcnt_q == 8'(GNT_TIMEOUT - 1));
  // Budget uses the count including this edge's phase, so GNT drops right after phase MAX_PHASES.
  assign budget_hit   = others_req && (pcnt_upd >= 8'(MAX_PHASES));

  always_comb begin
    owner_req  = 1'b0;
    others_req = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == owner_q) owner_req = !REQ[i];
      else if (!REQ[i])     others_req = 1'b1;
    end
  end

  // Rotating search: first low REQ at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_vld && cand == 4'(j) && !REQ[j]) begin
          win_vld = 1'b1;
          win_idx = 3'(j);
        end
      end
    end
    win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  end

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:    if (win_vld) state_nxt = S_GRANTED;
      S_GRANTED: begin
        if (!FRAME)                    state_nxt = S_BUSY;
        else if (!owner_req || tmo_hit) state_nxt = S_IDLE;
      end
      S_BUSY:    if (bus_idle_now) state_nxt = S_TURN;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt       = gnt_q;
    owner_nxt     = owner_q;
    owner_vld_nxt = owner_vld_q;
    ptr_nxt       = ptr_q;
    tcnt_nxt      = tcnt_q;
    pcnt_nxt      = pcnt_q;
    tmo_nxt       = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_nxt = '1;
        if (win_vld) begin
          gnt_nxt       = ~win_onehot;
          owner_nxt     = win_idx;
          owner_vld_nxt = 1'b1;
          tcnt_nxt      = '0;
          ptr_nxt       = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
        end
      end
      S_GRANTED: begin
        if (state_nxt == S_BUSY) begin
          pcnt_nxt = '0;
        end else if (state_nxt == S_IDLE) begin
          gnt_nxt       = '1;
          owner_vld_nxt = 1'b0;
          // An owner that withdrew its request is not a timeout.
          tmo_nxt       = owner_req;
        end else if (bus_idle_now) begin
          tcnt_nxt = tcnt_q + 8'd1;
        end
      end
      S_BUSY: begin
        pcnt_nxt = pcnt_upd;
        if (budget_hit || !owner_req || bus_idle_now) gnt_nxt = '1;
        if (bus_idle_now) owner_vld_nxt = 1'b0;
      end
      default: gnt_nxt = '1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      gnt_q       <= '1;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      ptr_q       <= '0;
      tcnt_q      <= '0;
      pcnt_q      <= '0;
      tmo_q       <= 1'b0;
      bus_idle_q  <= 1'b1;
    end else begin
      gnt_q       <= gnt_nxt;
      owner_q     <= owner_nxt;
      owner_vld_q <= owner_vld_nxt;
      ptr_q       <= ptr_nxt;
      tcnt_q      <= tcnt_nxt;
      pcnt_q      <= pcnt_nxt;
      tmo_q       <= tmo_nxt;
      bus_idle_q  <= bus_idle_now;
    end
  end

  assign GNT         = gnt_q;
  assign OWNER       = owner_q;
  assign OWNER_VALID = owner_vld_q;
  assign BUS_IDLE    = bus_idle_q;
  assign TIMEOUT_EV  = tmo_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed-vector bench for pci_bus_arbiter (N_REQ=4, GNT_TIMEOUT=16, MAX_PHASES=8).
module tb_pci_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic       FRAME;
  logic       IRDY;
  logic       TRDY;
  logic [3:0] GNT;
  logic [2:0] OWNER;
  logic       OWNER_VALID;
  logic       BUS_IDLE;
  logic       TIMEOUT_EV;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp4;

  pci_bus_arbiter #(.N_REQ(4), .GNT_TIMEOUT(16), .MAX_PHASES(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .FRAME(FRAME), .IRDY(IRDY), .TRDY(TRDY),
    .GNT(GNT), .OWNER(OWNER), .OWNER_VALID(OWNER_VALID), .BUS_IDLE(BUS_IDLE),
    .TIMEOUT_EV(TIMEOUT_EV)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    RST = 1'b0; REQ = 4'b0000; FRAME = 1'b1; IRDY = 1'b1; TRDY = 1'b1;
    tick; tick;
    chk("rst_gnt", GNT, 4'b1111);
    chk("rst_vld", OWNER_VALID, 1'b0);
    chk("rst_tmo", TIMEOUT_EV, 1'b0);
    chk("rst_idle", BUS_IDLE, 1'b1);
    chk("rst_owner", OWNER, 3'd0);
    RST = 1'b1;
    tick; tick;
    chk("rel_gnt", GNT, 4'b1110);
    chk("rel_owner", OWNER, 3'd0);
    chk("rel_vld", OWNER_VALID, 1'b1);

    // Round robin: every master requests, each runs a one-phase transaction.
    for (int k = 0; k < 4; k++) begin
      exp4 = ~(4'b0001 << k);
      chk("rr_gnt", GNT, exp4);
      chk("rr_owner", OWNER, k);
      FRAME = 1'b0; tick;
      chk("rr_addr_gnt", GNT, exp4);
      chk("rr_addr_idle", BUS_IDLE, 1'b0);
      FRAME = 1'b1; IRDY = 1'b0; TRDY = 1'b0; tick;
      chk("rr_data_vld", OWNER_VALID, 1'b1);
      IRDY = 1'b1; TRDY = 1'b1; tick;
      chk("rr_turn_gnt", GNT, 4'b1111);
      chk("rr_turn_vld", OWNER_VALID, 1'b0);
      tick;
      chk("rr_idle_gnt", GNT, 4'b1111);
      tick;
    end
    chk("rr_wrap_gnt", GNT, 4'b1110);
    chk("rr_wrap_owner", OWNER, 3'd0);
    REQ = 4'b1111; tick;
    chk("rr_drop_gnt", GNT, 4'b1111);

    // Timeout: master 2 never starts a transaction.
    REQ = 4'b1011; tick;
    for (int c = 0; c < 16; c++) begin
      chk("to_gnt", GNT, 4'b1011);
      chk("to_ev_low", TIMEOUT_EV, 1'b0);
      tick;
    end
    chk("to_revoke", GNT, 4'b1111);
    chk("to_ev", TIMEOUT_EV, 1'b1);
    REQ = 4'b1111; tick;
    chk("to_ev_pulse", TIMEOUT_EV, 1'b0);
    chk("to_idle_gnt", GNT, 4'b1111);

    // Early drop: master 2 withdraws before FRAME; pointer moves to 3.
    REQ = 4'b1011; tick;
    chk("ed_gnt", GNT, 4'b1011);
    chk("ed_owner", OWNER, 3'd2);
    REQ = 4'b1111; tick;
    chk("ed_release", GNT, 4'b1111);
    chk("ed_no_tmo", TIMEOUT_EV, 1'b0);
    chk("ed_vld", OWNER_VALID, 1'b0);
    REQ = 4'b0000; tick;
    chk("ed_ptr_gnt", GNT, 4'b0111);
    chk("ed_ptr_owner", OWNER, 3'd3);
    REQ = 4'b1111; tick;
    chk("ed_end_gnt", GNT, 4'b1111);

    // Budget preemption: master 1 starts requesting at phase 2 of a 20-phase burst.
    REQ = 4'b1110; tick;
    chk("bp_gnt", GNT, 4'b1110);
    FRAME = 1'b0; tick;
    for (int p = 1; p <= 20; p++) begin
      if (p >= 2) REQ = 4'b1100;
      FRAME = (p == 20); IRDY = 1'b0; TRDY = 1'b0;
      tick;
      exp4 = (p < 8) ? 4'b1110 : 4'b1111;
      chk("bp_phase_gnt", GNT, exp4);
      chk("bp_phase_vld", OWNER_VALID, 1'b1);
    end
    FRAME = 1'b1; IRDY = 1'b1; TRDY = 1'b1; tick;
    chk("bp_turn_gnt", GNT, 4'b1111);
    chk("bp_turn_vld", OWNER_VALID, 1'b0);
    tick;
    chk("bp_idle_gnt", GNT, 4'b1111);
    tick;
    chk("bp_next_gnt", GNT, 4'b1101);
    chk("bp_next_owner", OWNER, 3'd1);
    REQ = 4'b1111; tick;
    chk("bp_end_gnt", GNT, 4'b1111);

    // No contention: master 0 alone keeps its grant through 20 phases.
    REQ = 4'b1110; tick;
    chk("nc_gnt", GNT, 4'b1110);
    FRAME = 1'b0; tick;
    for (int p = 1; p <= 20; p++) begin
      FRAME = (p == 20); IRDY = 1'b0; TRDY = 1'b0;
      tick;
      chk("nc_phase_gnt", GNT, 4'b1110);
    end
    chk("nc_busy_idle", BUS_IDLE, 1'b0);
    FRAME = 1'b1; IRDY = 1'b1; TRDY = 1'b1; REQ = 4'b1111; tick;
    chk("nc_turn_gnt", GNT, 4'b1111);
    tick;

    // Stray FRAME with no grant only moves BUS_IDLE.
    FRAME = 1'b0; tick;
    chk("sf_idle", BUS_IDLE, 1'b0);
    chk("sf_gnt", GNT, 4'b1111);
    chk("sf_vld", OWNER_VALID, 1'b0);
    FRAME = 1'b1; tick;
    chk("sf_idle_back", BUS_IDLE, 1'b1);

    // Reset mid-transaction drops GNT at once and clears the pointer.
    REQ = 4'b1110; tick;
    chk("mr_gnt", GNT, 4'b1110);
    FRAME = 1'b0; tick;
    IRDY = 1'b0; TRDY = 1'b0; tick;
    chk("mr_busy_gnt", GNT, 4'b1110);
    RST = 1'b0; tick;
    chk("mr_rst_gnt", GNT, 4'b1111);
    chk("mr_rst_vld", OWNER_VALID, 1'b0);
    chk("mr_rst_idle", BUS_IDLE, 1'b1);
    RST = 1'b1; FRAME = 1'b1; IRDY = 1'b1; TRDY = 1'b1; REQ = 4'b1100; tick;
    chk("mr_ptr_gnt", GNT, 4'b1110);
    chk("mr_ptr_owner", OWNER, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central PCI bus arbiter that shares the shared AD/CBE/FRAME/IRDY bus between up to N_REQ initiators.
- Each initiator drives an active-low REQ; the arbiter returns one active-low GNT using rotating (round-robin) priority.
- It monitors FRAME/IRDY to detect bus idle, enforces a start-of-transaction timeout, and enforces a per-tenure data-phase budget when other requesters are waiting.
- Sits beside the PCI target devices; it does not touch AD.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GNT_TIMEOUT, 16, cycles a granted master may take to assert FRAME after the bus is idle before GNT is revoked (1..255).
- MAX_PHASES, 8, data phases a master may complete while others are pending before its GNT is removed (1..255).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous reset, active low.
- REQ  input  N_REQ  per-initiator request, active low.
- FRAME  input  1  bus FRAME, active low.
- IRDY  input  1  bus IRDY, active low.
- TRDY  input  1  bus TRDY, active low.
- GNT  output  N_REQ  per-initiator grant, active low; at most one bit low.
- OWNER  output  3  index of the granted/active initiator; valid only when OWNER_VALID=1.
- OWNER_VALID  output  1  high while any GNT is low or a granted transaction is in flight.
- BUS_IDLE  output  1  registered (FRAME & IRDY) from the previous cycle.
- TIMEOUT_EV  output  1  one-cycle pulse when a grant is revoked by GNT_TIMEOUT.

Behaviour:
- Reset (RST=0 at a rising edge):
  - GNT all ones, OWNER=0, OWNER_VALID=0, BUS_IDLE=1, TIMEOUT_EV=0.
  - Priority pointer = 0; counters = 0; state = IDLE.
  - Reset mid-transaction drops GNT the next edge, with no wait for bus idle.
- Bus idle is FRAME=1 and IRDY=1 sampled on the same edge.
- Arbitration picks the first low REQ searching from the pointer upward, wrapping modulo N_REQ. On each grant, pointer = granted index + 1, wrapping.
- State machine:
  - IDLE: GNT all high. If any REQ is low, compute the winner; next edge GNT[winner]=0, OWNER=winner, OWNER_VALID=1, go GRANTED, start the timeout counter at 0.
  - GRANTED: GNT held.
    - Bus idle and FRAME still high: increment the timeout counter.
    - FRAME sampled low (start of transaction): go BUSY, clear the phase counter.
    - Owner deasserts REQ before FRAME: release GNT next edge, go IDLE.
    - Counter reaches GNT_TIMEOUT-1 with FRAME high: release GNT, pulse TIMEOUT_EV for 1 cycle, go IDLE.
  - BUSY:
    - Count data phases: each edge with IRDY=0 and TRDY=0 increments the phase counter (8-bit, saturating at 255).
    - If any other REQ is low and phase counter >= MAX_PHASES, deassert GNT (master finishes its current phase, then releases FRAME).
    - If the owner REQ is high, deassert GNT.
    - GNT is never reasserted to a different master while in BUSY.
    - On first edge with bus idle: go TURN, OWNER_VALID=0.
  - TURN: one mandatory idle cycle with GNT all high; then go IDLE. Guarantees at least one clock with no grant between owners.
- Back-to-back same owner: if only the previous owner still requests, it is re-granted via TURN→IDLE→GRANTED (one cycle of bus parking is not used).
- Simultaneous requests: the lowest index at or after the pointer wins; no requester waits more than N_REQ-1 tenures.
- GNT changes only on the rising edge; no combinational path from REQ to GNT.
- A stray FRAME low with no grant (IDLE or TURN) is ignored except for updating BUS_IDLE.

Test Plan:
- Reset: RST=0 for 2 cycles with REQ=4'b0000 → GNT=4'b1111, OWNER_VALID=0, TIMEOUT_EV=0; after RST=1, GNT=4'b1110 on the 2nd edge.
- Round robin: all REQ held low, each master runs a 1-phase transaction → grant order 0,1,2,3,0, with one all-high TURN cycle between each.
- Timeout: REQ=4'b1011, FRAME/IRDY held high → GNT=4'b1011 for 16 cycles, then 4'b1111 with TIMEOUT_EV=1 for exactly one cycle.
- Budget preemption: master 0 bursts 20 phases, REQ[1] goes low at phase 2 → GNT[0] rises after phase 8; GNT[1] falls only after bus idle plus the TURN cycle.
- No contention: master 0 alone bursts 20 phases → GNT[0] stays low throughout.
- Early drop: grant to master 2, REQ[2] released before FRAME → GNT all high next edge, no TIMEOUT_EV, pointer = 3.
